bank_distributor: RTL
=====================

BANK_DISTRIBUTOR -- requirements
Module: bank_distributor

Interface
REQ-001 The block SHALL have these parameters:
- REQ_SIZE, default 16, request width in bits; minimum 4.
- DEPTH, default 2, per-bank queue depth in entries; power of two, minimum 2.
REQ-002 The block SHALL have these ports (name  direction  width  meaning):
- clk  input  1  single clock; all state on rising edge.
- rst_n  input  1  asynchronous, active-low reset.
- wr_en  input  1  push request for Data_in.
- Data_in  input  REQ_SIZE  request word; bits [3:0] select the target bank.
- full  output  1  target bank of current Data_in has no free entry.
- overflow  output  1  sticky flag: a push was attempted while full.
- Valid  output  16  per-bank head entry present.
- Data_out  output  16 x REQ_SIZE  per-bank head entry.
- Ready  input  16  per-bank consumer accepts head entry.
REQ-003 The block SHALL use one clock, clk, with asynchronous active-low reset rst_n; no other clock or reset.

Function
REQ-004 The block SHALL hold 16 independent FIFO queues of DEPTH entries each, one per bank.
- Per-bank state: read pointer, write pointer, occupancy count 0..DEPTH.
REQ-005 The target bank b SHALL be Data_in[3:0], decoded every cycle.
REQ-006 full SHALL be combinational: 1 exactly when count[b] == DEPTH for the current Data_in.
REQ-007 A push SHALL be accepted on a rising edge when wr_en=1 and full=0.
- Data_in is written at write pointer of bank b; pointer increments, wrapping DEPTH-1 -> 0.
REQ-008 A push with wr_en=1 and full=1 SHALL be dropped with no queue state change, and SHALL set overflow=1 from the next cycle until reset.
REQ-009 Valid[k] SHALL be 1 exactly when count[k] > 0, driven from registers.
REQ-010 Data_out[k] SHALL be the head entry when Valid[k]=1 and all zeros when Valid[k]=0.
REQ-011 A pop SHALL occur on bank k on a rising edge when Valid[k]=1 and Ready[k]=1; the read pointer increments with wrap-around.
REQ-012 Ready[k] while Valid[k]=0 SHALL be ignored.
REQ-013 Data_out[k] SHALL remain stable while Valid[k]=1 and Ready[k]=0.
REQ-014 Latency SHALL be one cycle.
- A word accepted at edge N appears on Valid/Data_out of an empty bank after edge N.
- There is no same-cycle bypass.
REQ-015 Push and pop on the same bank in the same edge SHALL both take effect when full=0, leaving count unchanged.
REQ-016 When count[b] == DEPTH, a same-edge pop SHALL NOT enable a push; full is evaluated on pre-edge count.
REQ-017 Pops on any subset of banks SHALL proceed in parallel in one edge, independently of the push.
REQ-018 Per-bank ordering SHALL be strict FIFO; no ordering is guaranteed across banks.
REQ-019 Count arithmetic SHALL never exceed DEPTH or go below 0 under any input combination.

Reset
REQ-020 While rst_n=0, the following SHALL hold:
- All pointers and counts are 0.
- Valid=16'h0000, Data_out all zeros, overflow=0.
- full reflects empty queues, i.e. 0.
REQ-021 Reset asserted mid-operation SHALL discard all queued entries immediately, without waiting for a clock edge.
REQ-022 The first push SHALL be accepted on the first rising edge after rst_n deasserts.

Verification
REQ-023 The bench SHALL cover these directed scenarios:
- Single push: wr_en=1, Data_in=16'hABC5, Ready=0 -> next cycle Valid=16'h0020, Data_out[5]=16'hABC5, all other Data_out=0.
- Fill: two pushes to bank 3 (16'h1113, 16'h2223), Ready=0 -> full=1 for Data_in[3:0]=3; a third push is dropped and overflow=1; after Ready[3]=1 for two cycles, outputs are 16'h1113 then 16'h2223, then Valid[3]=0.
- Simultaneous push/pop: bank 7 holds 1 entry, Ready[7]=1, push 16'h0007 -> count stays 1; Data_out[7]=16'h0007 next cycle.
- Full plus pop same edge: bank 2 full, Ready[2]=1, push to bank 2 -> push dropped, overflow=1, count becomes 1.
- Parallel drain: one entry in each of banks 0..15, Ready=16'hFFFF -> Valid goes 16'hFFFF -> 16'h0000 in one edge.
- Async reset: rst_n=0 between edges with queues non-empty -> Valid=0, Data_out=0, overflow=0 immediately.

Source files
------------

// File: rtl/bank_distributor.sv
// Sixteen-bank request distributor: each request lands in the FIFO selected by Data_in[3:0],
// and each bank presents its head entry to an independent valid/ready consumer.
module bank_distributor #(
  parameter int unsigned REQ_SIZE = 16,
  parameter int unsigned DEPTH    = 2
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic                      wr_en,
  input  logic [REQ_SIZE-1:0]       Data_in,
  output logic                      full,
  output logic                      overflow,
  output logic [15:0]               Valid,
  output logic [15:0][REQ_SIZE-1:0] Data_out,
  input  logic [15:0]               Ready
);

  localparam int unsigned NumBanks = 16;
  localparam int unsigned PtrW     = $clog2(DEPTH);
  localparam int unsigned CntW     = $clog2(DEPTH + 1);

  logic [REQ_SIZE-1:0] mem_q    [NumBanks][DEPTH];
  logic [PtrW-1:0]     rd_ptr_q [NumBanks];
  logic [PtrW-1:0]     rd_ptr_d [NumBanks];
  logic [PtrW-1:0]     wr_ptr_q [NumBanks];
  logic [PtrW-1:0]     wr_ptr_d [NumBanks];
  logic [CntW-1:0]     cnt_q    [NumBanks];
  logic [CntW-1:0]     cnt_d    [NumBanks];
  logic                overflow_q, overflow_d;

  logic [3:0] bank;
  logic       push;

  assign bank = Data_in[3:0];

  // full looks at the pre-edge count only, so a same-edge pop never frees room for a push.
  always_comb begin
    full = (cnt_q[bank] == CntW'(DEPTH));
    push = wr_en & ~full;
  end

  always_comb begin
    Valid    = '0;
    Data_out = '0;
    for (int k = 0; k < NumBanks; k++) begin
      Valid[k] = (cnt_q[k] != '0);
      if (Valid[k]) begin
        Data_out[k] = mem_q[k][rd_ptr_q[k]];
      end
    end
  end

  always_comb begin
    rd_ptr_d   = rd_ptr_q;
    wr_ptr_d   = wr_ptr_q;
    cnt_d      = cnt_q;
    overflow_d = overflow_q | (wr_en & full);
    for (int k = 0; k < NumBanks; k++) begin
      logic pop_k, push_k;
      pop_k  = Valid[k] & Ready[k];
      push_k = push & (bank == 4'(k));
      // DEPTH is a power of two, so pointer wrap is plain overflow.
      if (pop_k) begin
        rd_ptr_d[k] = rd_ptr_q[k] + PtrW'(1);
      end
      if (push_k) begin
        wr_ptr_d[k] = wr_ptr_q[k] + PtrW'(1);
      end
      if (push_k && !pop_k) begin
        cnt_d[k] = cnt_q[k] + CntW'(1);
      end else if (pop_k && !push_k) begin
        cnt_d[k] = cnt_q[k] - CntW'(1);
      end
    end
  end

  // Storage needs no reset; stale words are masked by Valid.
  always_ff @(posedge clk) begin
    if (push) begin
      mem_q[bank][wr_ptr_q[bank]] <= Data_in;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rd_ptr_q   <= '{default: '0};
      wr_ptr_q   <= '{default: '0};
      cnt_q      <= '{default: '0};
      overflow_q <= 1'b0;
    end else begin
      rd_ptr_q   <= rd_ptr_d;
      wr_ptr_q   <= wr_ptr_d;
      cnt_q      <= cnt_d;
      overflow_q <= overflow_d;
    end
  end

  assign overflow = overflow_q;

endmodule
